seq_divider: RTL

//  Multi-cycle unsigned restoring divider: quotient = dividend / divisor and

---
 rtl/arith_pkg.sv | 20 ++
 rtl/addsub_n.sv | 26 ++
 rtl/seq_divider.sv | 124 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: divider state encoding and a constant-safe
// ceil(log2) helper used to size iteration counters.
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int clog2_w(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_n.sv
// N-bit ripple-carry adder/subtractor: m=0 gives a+b, m=1 gives a-b
// (b inverted, carry-in set). cout=1 in subtract mode means no borrow.
module addsub_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         m,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = m;

    for (genvar i = 0; i < N; i++) begin : g_fa
        logic bx;
        assign bx       = b[i] ^ m;
        assign s[i]     = a[i] ^ bx ^ c[i];
        assign c[i+1]   = (a[i] & bx) | (a[i] & c[i]) | (bx & c[i]);
    end

    assign cout = c[N];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one trial subtraction per clock through a shared
// add/subtract unit; results and divide-by-zero flag are held after completion.
//
//   state  | meaning
//   S_IDLE | waiting for start
//   S_CALC | iterating, one quotient bit per cycle (busy=1)
//   S_DONE | one-cycle done pulse; a start here is accepted immediately
module seq_divider
    import arith_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = clog2_w(W + 1);

    state_e        state_q, state_d;
    logic [W:0]    r_q, r_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [W:0]    rs;
    logic [W:0]    t;
    logic          no_borrow;
    logic          unused_r_msb;

    // After each restore step R < D, so the top bit of R never feeds the shift.
    assign rs           = {r_q[W-1:0], q_q[W-1]};
    assign unused_r_msb = r_q[W];

    addsub_n #(.N(W + 1)) u_addsub (
        .a    (rs),
        .b    ({1'b0, d_q}),
        .m    (1'b1),
        .s    (t),
        .cout (no_borrow)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    r_d   = '0;
                    q_d   = dividend;
                    d_d   = divisor;
                    cnt_d = CW'(W);
                    if (divisor != '0) begin
                        state_d = S_CALC;
                    end else begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                r_d   = no_borrow ? t : rs;
                q_d   = {q_q[W-2:0], no_borrow};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    quo_d   = q_d;
                    rem_d   = r_d[W-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
